// File: rtl/shift_seq_unit.sv
// -----------------------------------------------------------------------------
// shift_seq_unit
//   Multi-cycle shift sequencer for the ALU shift path. It takes one request
//   (operand, amount, direction) over a valid/ready port, shifts by one bit per
//   clock and presents the result, a zero flag and the last bit shifted out on
//   a second valid/ready port.
//
//   Optional feature: define SHIFT_ROTATE_EN to honour in_rot (rotate instead of
//   a logical shift). Without it, in_rot is ignored and all shifts zero-fill.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid / in_ready     request handshake
//   in_a, in_amt            operand, shift amount
//   in_dir                  0 = left, 1 = right
//   in_rot                  1 = rotate (SHIFT_ROTATE_EN builds only)
//   out_valid / out_ready   result handshake
//   out_y, out_zero         result and (out_y == 0)
//   out_carry               last bit shifted out / wrapped, 0 for amount 0
//   busy                    sequencer not idle
// -----------------------------------------------------------------------------
// state   | meaning
// S_IDLE  | waiting for a request, in_ready high
// S_SHIFT | shifting one bit per clock, count holds remaining steps
// S_DONE  | result held on out_*, waiting for out_ready
// -----------------------------------------------------------------------------
module shift_seq_unit #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    input  logic             in_rot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_carry,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] shifted;
    logic [AMT_W-1:0] count_q;
    logic             dir_q;
    logic             carry_q;
    logic             shift_out;
    logic             fill;
    logic             wrap_en;
    logic             last_step;

`ifdef SHIFT_ROTATE_EN
    logic rot_q;

    assign wrap_en = rot_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_q <= 1'b0;
        end else if (state_q == S_IDLE && in_valid) begin
            rot_q <= in_rot;
        end
    end
`else
    logic unused_rot;

    assign unused_rot = in_rot;
    assign wrap_en    = 1'b0;
`endif

    assign last_step = (count_q == AMT_W'(1));

    // One-bit step of the working register; the bit leaving one end either
    // wraps into the other end (rotate) or is replaced by zero.
    always_comb begin
        shift_out = 1'b0;
        fill      = 1'b0;
        shifted   = work_q;
        if (dir_q) begin
            shift_out = work_q[0];
            fill      = wrap_en & work_q[0];
            shifted   = {fill, work_q[WIDTH-1:1]};
        end else begin
            shift_out = work_q[WIDTH-1];
            fill      = wrap_en & work_q[WIDTH-1];
            shifted   = {work_q[WIDTH-2:0], fill};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_d = (in_amt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q   <= '0;
            count_q  <= '0;
            dir_q    <= 1'b0;
            carry_q  <= 1'b0;
            out_y    <= '0;
            out_zero <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        work_q  <= in_a;
                        dir_q   <= in_dir;
                        count_q <= in_amt;
                        carry_q <= 1'b0;
                        if (in_amt == '0) begin
                            out_y    <= in_a;
                            out_zero <= (in_a == '0);
                        end
                    end
                end
                S_SHIFT: begin
                    work_q  <= shifted;
                    carry_q <= shift_out;
                    count_q <= count_q - AMT_W'(1);
                    // Result and zero flag are captured together on the final step
                    // so both stay frozen while the consumer stalls.
                    if (last_step) begin
                        out_y    <= shifted;
                        out_zero <= (shifted == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_carry = carry_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
module tb_shift_seq_unit;

    localparam int W = 4;
    localparam int A = 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [A-1:0] in_amt;
    logic         in_dir;
    logic         in_rot;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_y;
    logic         out_zero;
    logic         out_carry;
    logic         busy;

    int checks = 0;
    int errors = 0;

    shift_seq_unit #(.WIDTH(W), .AMT_W(A)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .in_rot    (in_rot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero),
        .out_carry (out_carry),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result computed arithmetically on whole words.
    task automatic ref_shift(input int a, input int amt, input int dir, input int rot,
                             output int y, output int c);
        int mask;
        int do_rot;
        mask   = (1 << W) - 1;
        do_rot = 0;
`ifdef SHIFT_ROTATE_EN
        do_rot = rot;
`endif
        if (do_rot == 0 && rot > 1) do_rot = 0;
        if (dir == 0) begin
            if (do_rot != 0) begin
                y = ((a << amt) | (a >> (W - amt))) & mask;
                c = (amt == 0) ? 0 : (y & 1);
            end else begin
                y = (a << amt) & mask;
                c = (amt == 0) ? 0 : ((a >> (W - amt)) & 1);
            end
        end else begin
            if (do_rot != 0) begin
                y = ((a >> amt) | (a << (W - amt))) & mask;
                c = (amt == 0) ? 0 : ((y >> (W - 1)) & 1);
            end else begin
                y = a >> amt;
                c = (amt == 0) ? 0 : ((a >> (amt - 1)) & 1);
            end
        end
    endtask

    // Timeline model: a request accepted in cycle N is valid from cycle N+1+amt
    // until the cycle in which out_ready is seen.
    int cyc;
    int vcyc;
    bit pend;
    int e_y, e_c;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend = 1'b0;
            cyc  = 0;
            vcyc = 0;
        end else begin
            if (!pend) begin
                if (in_valid) begin
                    pend = 1'b1;
                    vcyc = cyc + 1 + int'(in_amt);
                    ref_shift(int'(in_a), int'(in_amt), int'(in_dir), int'(in_rot), e_y, e_c);
                end
            end else if (cyc >= vcyc && out_ready) begin
                pend = 1'b0;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        bit exp_v;
        if (rst_n) begin
            exp_v = pend && (cyc >= vcyc);
            chk("out_valid", int'(out_valid), int'(exp_v));
            chk("busy", int'(busy), int'(pend));
            chk("in_ready", int'(in_ready), int'(!pend));
            if (exp_v && out_valid) begin
                chk("out_y", int'(out_y), e_y);
                chk("out_carry", int'(out_carry), e_c);
                chk("out_zero", int'(out_zero), int'(e_y == 0));
            end
        end
    end

    // Issues one request from an idle sequencer (called at a falling edge) and
    // checks latency and the literal result; out_ready is held high.
    task automatic do_req(input string name, input int a, input int amt, input int dir,
                          input int rot, input int ey, input int ec, input int ez);
        int k;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = W'(a);
        in_amt    = A'(amt);
        in_dir    = dir[0];
        in_rot    = rot[0];
        chk({name, "_in_ready"}, int'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = ~in_a;
        k        = 1;
        while (!out_valid && k < 12) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_latency"}, k, 1 + amt);
        chk({name, "_y"}, int'(out_y), ey);
        chk({name, "_carry"}, int'(out_carry), ec);
        chk({name, "_zero"}, int'(out_zero), ez);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_amt    = '0;
        in_dir    = 1'b0;
        in_rot    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_y", int'(out_y), 0);
        chk("rst_out_zero", int'(out_zero), 0);
        chk("rst_out_carry", int'(out_carry), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        do_req("t1", 4'b1011, 1, 0, 0, 4'b0110, 1, 0);
        do_req("t2", 4'b1011, 3, 1, 0, 4'b0001, 0, 0);
        do_req("t3a", 4'b1001, 0, 0, 0, 4'b1001, 0, 0);
        do_req("t3b", 4'b0001, 1, 1, 0, 4'b0000, 1, 1);
        do_req("t_lsb_to_msb", 4'b0111, 3, 0, 0, 4'b1000, 1, 0);
`ifdef SHIFT_ROTATE_EN
        do_req("t6", 4'b1011, 2, 0, 1, 4'b1110, 0, 0);
`else
        do_req("t6", 4'b1011, 2, 0, 1, 4'b1100, 0, 0);
`endif

        // Consumer stall: result must hold while new requests are ignored.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 4'b1011;
        in_amt    = 2'd1;
        in_dir    = 1'b0;
        in_rot    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t4_valid", int'(out_valid), 1);
            chk("t4_y", int'(out_y), 4'b0110);
            chk("t4_carry", int'(out_carry), 1);
            chk("t4_in_ready", int'(in_ready), 0);
            in_valid = i[0];
            in_a     = W'(i + 3);
            in_amt   = A'(i);
            in_dir   = ~i[0];
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_after_valid", int'(out_valid), 0);
        chk("t4_after_in_ready", int'(in_ready), 1);

        // Reset in the middle of a shift discards the request.
        in_valid = 1'b1;
        in_a     = 4'b1011;
        in_amt   = 2'd3;
        in_dir   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", int'(out_valid), 0);
        chk("t5_y", int'(out_y), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_req("t5_after", 4'b1011, 1, 0, 0, 4'b0110, 1, 0);

        // Random traffic checked every cycle against the timeline model.
        repeat (3000) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = W'($urandom_range(0, 15));
            in_amt    = A'($urandom_range(0, 3));
            in_dir    = 1'($urandom_range(0, 1));
            in_rot    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
